// File: rtl/switch_conditioner_pkg.sv
// Shared constants and types for the switch conditioner slice.
// Optional feature macro: SWITCH_CONDITIONER_AUTO_REPEAT_EN (see debounce_channel).
package switch_cond_pkg;

  localparam int unsigned NSW_DEF           = 8;
  localparam int unsigned DEB_CYCLES_DEF    = 4;
  localparam int unsigned REPEAT_DELAY_DEF  = 16;
  localparam int unsigned REPEAT_PERIOD_DEF = 8;

  typedef logic [NSW_DEF-1:0] sw_vec_t;

  // Auto-repeat phase: waiting for the first repeat, or for the periodic ones.
  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_FIRST,
    RPT_NEXT
  } rpt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch bundle: raw inputs toward the conditioner, clean level and edge pulses back.
interface switch_conditioner_if
  import switch_cond_pkg::*;
#(
    parameter int unsigned NSW = NSW_DEF
);
    logic [NSW-1:0] sw_raw;
    logic [NSW-1:0] sw_level;
    logic [NSW-1:0] sw_rise;
    logic [NSW-1:0] sw_fall;

    modport master(output sw_raw, input sw_level, input sw_rise, input sw_fall);
    modport slave(input sw_raw, output sw_level, output sw_rise, output sw_fall);
endinterface

// File: rtl/switch_conditioner_debounce_channel.sv
// One switch channel: 2-FF synchronizer, debounce counter, registered level and edge pulses.
// With SWITCH_CONDITIONER_AUTO_REPEAT_EN defined, a held-high level re-pulses rise.
module debounce_channel
  import switch_cond_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          accept;

`ifdef SWITCH_CONDITIONER_AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] RPT_FIRST_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT_LAST  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    rpt_state_t    rpt_state;
    logic [RW-1:0] rpt_last;

    always_comb begin
        rpt_last = (rpt_state == RPT_NEXT) ? RPT_NEXT_LAST : RPT_FIRST_LAST;
    end
`endif

    always_comb begin
        accept = (sync != level) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
`ifdef SWITCH_CONDITIONER_AUTO_REPEAT_EN
            rcnt      <= '0;
            rpt_state <= RPT_IDLE;
`endif
        end else begin
            meta <= raw;
            sync <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            if (accept) begin
                level <= sync;
                cnt   <= '0;
                rise  <= sync;
                fall  <= ~sync;
            end else if (sync == level) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
`ifdef SWITCH_CONDITIONER_AUTO_REPEAT_EN
            // Repeat timer restarts on every accepted edge; it only runs while level stays high.
            if (!level || accept) begin
                rcnt      <= '0;
                rpt_state <= (accept && sync) ? RPT_FIRST : RPT_IDLE;
            end else if (rcnt == rpt_last) begin
                rise      <= 1'b1;
                rcnt      <= '0;
                rpt_state <= RPT_NEXT;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Top: NSW independent debounce channels conditioning raw slide switches into clk_2.
// Optional auto-repeat on held switches: define SWITCH_CONDITIONER_AUTO_REPEAT_EN.
module switch_conditioner
  import switch_cond_pkg::*;
#(
    parameter int unsigned NSW           = NSW_DEF,
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input logic                 clk_2,
    input logic                 reset_n,
    switch_conditioner_if.slave sw_if
);

    logic [NSW-1:0] level_v;
    logic [NSW-1:0] rise_v;
    logic [NSW-1:0] fall_v;

    for (genvar i = 0; i < NSW; i++) begin : g_ch
        debounce_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk_2  (clk_2),
            .reset_n(reset_n),
            .raw    (sw_if.sw_raw[i]),
            .level  (level_v[i]),
            .rise   (rise_v[i]),
            .fall   (fall_v[i])
        );
    end

    assign sw_if.sw_level = level_v;
    assign sw_if.sw_rise  = rise_v;
    assign sw_if.sw_fall  = fall_v;

endmodule
